// File: rtl/core_launch_controller.sv
// Launch sequencer for one compute unit: loads a program into global memory,
// starts the core, waits for halt or watchdog, then streams a block of results back.
module core_launch_controller #(
  parameter int addr_width      = 32,
  parameter int data_width      = 32,
  parameter int count_width     = 16,
  parameter int watchdog_cycles = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [addr_width-1:0]  load_addr,
  input  logic [data_width-1:0]  start_pc,
  input  logic [addr_width-1:0]  res_addr,
  input  logic [count_width-1:0] res_count,
  input  logic                   prog_valid,
  output logic                   prog_ready,
  input  logic [data_width-1:0]  prog_data,
  input  logic                   prog_last,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [data_width-1:0]  res_data,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   contr_mem_wr_en,
  output logic [addr_width-1:0]  contr_mem_wr_addr,
  output logic [data_width-1:0]  contr_mem_wr_data,
  output logic                   contr_mem_rd_en,
  output logic [addr_width-1:0]  contr_mem_rd_addr,
  input  logic [data_width-1:0]  contr_mem_rd_data,
  input  logic                   contr_mem_rd_ack,
  output logic                   contr_core1_clr,
  output logic                   contr_core1_set_pc_req,
  output logic [data_width-1:0]  contr_core1_set_pc_addr,
  output logic                   contr_core1_ena,
  input  logic                   contr_core1_halt
);

  localparam int wd_width = $clog2(watchdog_cycles + 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, CLEAR, SET_PC, RUN, READ_REQ, READ_WAIT, READ_OUT, DONE
  } state_t;

  state_t state, state_nxt;

  logic [addr_width-1:0]  wr_ptr;
  logic [addr_width-1:0]  rd_ptr;
  logic [data_width-1:0]  pc_q;
  logic [data_width-1:0]  res_q;
  logic [count_width-1:0] remaining;
  logic [wd_width-1:0]    wd_cnt;
  logic                   timeout_q;

  logic prog_fire;
  logic res_fire;
  logic halt_seen;
  logic wd_expired;

  assign prog_fire  = (state == LOAD) && prog_valid;
  assign res_fire   = (state == READ_OUT) && res_ready;
  // wd_cnt == 0 marks the first RUN cycle, where a halt left over from a
  // previous launch must not be trusted.
  assign halt_seen  = (state == RUN) && (wd_cnt != '0) && contr_core1_halt;
  assign wd_expired = (state == RUN) && (wd_cnt == wd_width'(watchdog_cycles - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = LOAD;
      LOAD:      if (prog_fire && prog_last) state_nxt = CLEAR;
      CLEAR:     state_nxt = SET_PC;
      SET_PC:    state_nxt = RUN;
      RUN: begin
        if (halt_seen)       state_nxt = (remaining != '0) ? READ_REQ : DONE;
        else if (wd_expired) state_nxt = DONE;
      end
      READ_REQ:  state_nxt = READ_WAIT;
      READ_WAIT: if (contr_mem_rd_ack) state_nxt = READ_OUT;
      READ_OUT:  if (res_ready) state_nxt = (remaining == count_width'(1)) ? DONE : READ_REQ;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prog_ready              = (state == LOAD);
    contr_core1_clr         = (state == CLEAR);
    contr_core1_set_pc_req  = (state == SET_PC);
    contr_core1_set_pc_addr = pc_q;
    contr_core1_ena         = (state == RUN);
    contr_mem_rd_en         = (state == READ_REQ);
    contr_mem_rd_addr       = rd_ptr;
    res_valid               = (state == READ_OUT);
    res_data                = res_q;
    busy                    = (state != IDLE);
    done                    = (state == DONE);
    timeout                 = timeout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      pc_q              <= '0;
      res_q             <= '0;
      remaining         <= '0;
      wd_cnt            <= '0;
      timeout_q         <= 1'b0;
      contr_mem_wr_en   <= 1'b0;
      contr_mem_wr_addr <= '0;
      contr_mem_wr_data <= '0;
    end else begin
      contr_mem_wr_en <= prog_fire;
      wd_cnt          <= (state == RUN) ? wd_cnt + wd_width'(1) : '0;

      if (state == IDLE && start) begin
        wr_ptr    <= load_addr;
        pc_q      <= start_pc;
        rd_ptr    <= res_addr;
        remaining <= res_count;
        timeout_q <= 1'b0;
      end

      if (prog_fire) begin
        contr_mem_wr_addr <= wr_ptr;
        contr_mem_wr_data <= prog_data;
        wr_ptr            <= wr_ptr + addr_width'(4);
      end

      // A halt arriving on the expiry cycle still counts as a clean finish.
      if (wd_expired && !halt_seen) timeout_q <= 1'b1;

      if (state == READ_WAIT && contr_mem_rd_ack) res_q <= contr_mem_rd_data;

      if (res_fire) begin
        remaining <= remaining - count_width'(1);
        rd_ptr    <= rd_ptr + addr_width'(4);
      end
    end
  end

endmodule

// File: tb/tb_core_launch_controller.sv
// Bench for core_launch_controller: table of launch scenarios plus reset sequences,
// with a small core model, a latency-configurable memory model and an event monitor.
module tb_core_launch_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] load_addr, start_pc, res_addr;
  logic [15:0] res_count;
  logic        prog_valid, prog_ready, prog_last;
  logic [31:0] prog_data;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        busy, done, timeout;
  logic        wr_en, rd_en, rd_ack;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic        clr, set_pc_req, ena, halt;
  logic [31:0] set_pc_addr;

  core_launch_controller #(
    .addr_width(32), .data_width(32), .count_width(16), .watchdog_cycles(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_addr(load_addr), .start_pc(start_pc), .res_addr(res_addr), .res_count(res_count),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_data(prog_data), .prog_last(prog_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .timeout(timeout),
    .contr_mem_wr_en(wr_en), .contr_mem_wr_addr(wr_addr), .contr_mem_wr_data(wr_data),
    .contr_mem_rd_en(rd_en), .contr_mem_rd_addr(rd_addr),
    .contr_mem_rd_data(rd_data), .contr_mem_rd_ack(rd_ack),
    .contr_core1_clr(clr), .contr_core1_set_pc_req(set_pc_req),
    .contr_core1_set_pc_addr(set_pc_addr), .contr_core1_ena(ena), .contr_core1_halt(halt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] load_addr;
    logic [31:0] start_pc;
    logic [31:0] res_addr;
    logic [15:0] res_count;
    int          nbeats;
    int          halt_after;  // 0 = never halt
    bit          stale;       // halt held high throughout
    int          bp;          // res_ready low cycles on first result
    int          ack_lat;
    bit          poke;        // pulse start again while busy
    logic [31:0] r0, r1;      // memory contents at res_addr, res_addr+4
    int          exp_ena;
    bit          exp_to;
    int          exp_rd;
    logic [31:0] exp_last_wr;
    int          exp_stall;
  } vec_t;

  vec_t vecs[7];

  int total = 0;
  int bad   = 0;

  // scenario configuration, written by the main sequence only
  int halt_after_cfg = 0;
  bit stale_cfg      = 1'b0;
  int bp_cfg         = 0;
  int lat_cfg        = 1;

  logic [31:0] res_mem  [logic [31:0]];
  logic [31:0] prog_mem [logic [31:0]];

  // monitor state, written by the monitor only
  logic [31:0] wr_a[$], wr_d[$], rd_q[$], out_q[$];
  int cyc = 0, clr_n = 0, setpc_n = 0, ena_n = 0, done_n = 0, stall_n = 0, viol_n = 0;
  int clr_cyc = 0, setpc_cyc = 0, ena_first = 0, last_wr_cyc = 0;
  logic [31:0] setpc_val = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // core model: halts after halt_after enabled cycles
  initial begin : core_model
    int run_cyc;
    run_cyc = 0;
    halt = 1'b0;
    forever begin
      tick();
      if (ena) run_cyc++;
      else     run_cyc = 0;
      halt = stale_cfg || (halt_after_cfg != 0 && run_cyc >= halt_after_cfg);
    end
  end

  // memory read model with fixed ack latency
  initial begin : mem_model
    int pend;
    logic [31:0] pa;
    pend = 0;
    pa = 0;
    rd_ack = 1'b0;
    rd_data = 0;
    forever begin
      tick();
      rd_ack = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rd_ack = 1'b1;
          if (res_mem.exists(pa))       rd_data = res_mem[pa];
          else if (prog_mem.exists(pa)) rd_data = prog_mem[pa];
          else                          rd_data = 0;
        end
      end
      if (rd_en) begin
        pend = lat_cfg;
        pa = rd_addr;
      end
    end
  end

  // result consumer: stalls the first result word of each launch for bp_cfg cycles
  initial begin : ready_drv
    int stalled;
    stalled = 0;
    res_ready = 1'b0;
    forever begin
      tick();
      if (!busy) stalled = 0;
      if (res_valid && stalled < bp_cfg) begin
        res_ready = 1'b0;
        stalled++;
      end else begin
        res_ready = res_valid;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (start && !busy && !rst) begin
        wr_a.delete(); wr_d.delete(); rd_q.delete(); out_q.delete();
        clr_n = 0; setpc_n = 0; ena_n = 0; done_n = 0; stall_n = 0; viol_n = 0;
      end
      if ((wr_en && rd_en) || (ena && (clr || set_pc_req || rd_en || done))) viol_n++;
      if (wr_en) begin
        wr_a.push_back(wr_addr);
        wr_d.push_back(wr_data);
        prog_mem[wr_addr] = wr_data;
        last_wr_cyc = cyc;
      end
      if (rd_en) rd_q.push_back(rd_addr);
      if (clr) begin clr_n++; clr_cyc = cyc; end
      if (set_pc_req) begin setpc_n++; setpc_cyc = cyc; setpc_val = set_pc_addr; end
      if (ena) begin
        if (ena_n == 0) ena_first = cyc;
        ena_n++;
      end
      if (done) done_n++;
      if (res_valid && !res_ready) stall_n++;
      if (res_valid && res_ready) out_q.push_back(res_data);
    end
  end

  task automatic start_launch(input vec_t v);
    int g;
    halt_after_cfg = v.halt_after;
    stale_cfg      = v.stale;
    bp_cfg         = v.bp;
    lat_cfg        = v.ack_lat;
    res_mem[v.res_addr]      = v.r0;
    res_mem[v.res_addr + 4]  = v.r1;
    load_addr = v.load_addr;
    start_pc  = v.start_pc;
    res_addr  = v.res_addr;
    res_count = v.res_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("timeout_cleared_on_start", 32'(timeout), 0);
    chk("busy_after_start", 32'(busy), 1);
    for (int i = 0; i < v.nbeats; i++) begin
      prog_valid = 1'b1;
      prog_data  = 32'h0000000A + 32'(i);
      prog_last  = (i == v.nbeats - 1);
      g = 0;
      while (!prog_ready && g < 50) begin tick(); g++; end
      if (g >= 50) chk("prog_ready_wait", 0, 1);
      tick();
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    if (v.poke) begin
      load_addr = 32'hDEAD0000;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic finish_launch(input vec_t v);
    int g;
    g = 0;
    while (done_n == 0 && g < 600) begin tick(); g++; end
    if (g >= 600) chk("done_wait", 0, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("done_pulses", done_n, 1);
    chk("busy_idle", 32'(busy), 0);
    chk("timeout_sticky", 32'(timeout), 32'(v.exp_to));
    chk("wr_count", wr_a.size(), v.nbeats);
    if (wr_a.size() > 0) begin
      chk("wr_first_addr", wr_a[0], v.load_addr);
      chk("wr_last_addr", wr_a[wr_a.size()-1], v.exp_last_wr);
      chk("wr_last_data", wr_d[wr_d.size()-1], 32'h0000000A + 32'(v.nbeats - 1));
    end
    chk("clr_pulses", clr_n, 1);
    chk("clr_with_last_wr", clr_cyc, last_wr_cyc);
    chk("setpc_pulses", setpc_n, 1);
    chk("setpc_after_clr", setpc_cyc, clr_cyc + 1);
    chk("setpc_addr", setpc_val, v.start_pc);
    chk("ena_after_setpc", ena_first, setpc_cyc + 1);
    chk("ena_cycles", ena_n, v.exp_ena);
    chk("rd_count", rd_q.size(), v.exp_rd);
    chk("res_count_out", out_q.size(), v.exp_rd);
    if (rd_q.size() > 0) chk("rd_addr0", rd_q[0], v.res_addr);
    if (rd_q.size() > 1) chk("rd_addr1", rd_q[1], v.res_addr + 4);
    if (out_q.size() > 0) chk("res_data0", out_q[0], v.r0);
    if (out_q.size() > 1) chk("res_data1", out_q[1], v.r1);
    chk("res_stall_cycles", stall_n, v.exp_stall);
    chk("strobe_invariant", viol_n, 0);
  endtask

  initial begin : main
    int g;
    //         load          pc            res          cnt beats halt stale bp lat poke r0     r1     ena to rd last_wr      stall
    vecs[0] = '{32'h100,      32'h100,      32'h200,  16'd2, 3, 10, 0, 0, 3, 0, 32'h11, 32'h22, 10, 0, 2, 32'h108,      0};
    vecs[1] = '{32'h300,      32'h340,      32'h400,  16'd2, 1,  4, 0, 5, 1, 0, 32'h33, 32'h44,  4, 0, 2, 32'h300,      5};
    vecs[2] = '{32'h500,      32'h500,      32'h600,  16'd2, 2,  0, 0, 0, 2, 0, 32'h55, 32'h66, 20, 1, 0, 32'h504,      0};
    vecs[3] = '{32'h700,      32'h704,      32'h780,  16'd0, 1,  3, 0, 0, 2, 0, 32'h0,  32'h0,   3, 0, 0, 32'h700,      0};
    vecs[4] = '{32'h800,      32'h800,      32'h880,  16'd1, 2,  0, 1, 0, 2, 1, 32'h77, 32'h0,   2, 0, 1, 32'h804,      0};
    vecs[5] = '{32'hFFFFFFF8, 32'hFFFFFFF8, 32'h1000, 16'd1, 3,  2, 0, 0, 4, 0, 32'h99, 32'h0,   2, 0, 1, 32'h0,        0};
    vecs[6] = '{32'h900,      32'h900,      32'h980,  16'd1, 1, 20, 0, 2, 3, 0, 32'hAB, 32'h0,  20, 0, 1, 32'h900,      2};

    rst = 1'b1;
    start = 1'b0;
    load_addr = 0; start_pc = 0; res_addr = 0; res_count = 0;
    prog_valid = 1'b0; prog_data = 0; prog_last = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_strobes", 32'({prog_ready, res_valid, busy, done, timeout, wr_en, rd_en, clr, set_pc_req, ena}), 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_res_data", res_data, 0);
    chk("reset_setpc_addr", set_pc_addr, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      start_launch(vecs[i]);
      finish_launch(vecs[i]);
    end

    // reset while the core is running
    start_launch(vecs[2]);
    g = 0;
    while (!ena && g < 50) begin tick(); g++; end
    chk("ena_before_reset", 32'(ena), 1);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrun_reset_outputs", 32'({ena, busy, done, wr_en, rd_en, clr, set_pc_req, prog_ready, res_valid, timeout}), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_after_reset", 32'(busy), 0);
    start_launch(vecs[0]);
    finish_launch(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
